// File: rtl/model_config_shadow_mem_pkg.sv
// Shared types and helpers for the double-buffered model configuration memory.
package model_config_pkg;

    // Controller states: accepting host writes, waiting on the accelerator, copying back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    // Well-known table ids; the remaining tables are reserved.
    localparam int TBL_MODEL_PARAMS = 0;
    localparam int TBL_FWD_SPARSITY = 1;

    // Decoded host address. Fields are wide enough for any supported geometry;
    // callers slice out the bits they need.
    typedef struct packed {
        logic [31:0] table_id;
        logic [31:0] idx;
        logic        legal;
    } addr_dec_t;

    // Split a host address into table/index and flag any stray bits:
    // bits in the gap between the index and the table field, bits above the
    // table field, or a table id past the last implemented table.
    function automatic addr_dec_t decode_addr(
        input logic [63:0] addr,
        input int unsigned addr_w,
        input int unsigned tsel_lsb,
        input int unsigned tbl_w,
        input int unsigned idx_w,
        input int unsigned num_tables
    );
        addr_dec_t   dec;
        logic [63:0] idx_mask;
        logic [63:0] tbl_mask;
        logic [63:0] gap_mask;
        logic [63:0] high_mask;
        idx_mask  = (64'd1 << idx_w) - 64'd1;
        tbl_mask  = (64'd1 << tbl_w) - 64'd1;
        gap_mask  = ((64'd1 << tsel_lsb) - 64'd1) & ~idx_mask;
        high_mask = ((64'd1 << addr_w) - 64'd1) & ~((64'd1 << (tsel_lsb + tbl_w)) - 64'd1);
        dec.idx      = 32'(addr & idx_mask);
        dec.table_id = 32'((addr >> tsel_lsb) & tbl_mask);
        dec.legal    = (dec.table_id < num_tables) &&
                       ((addr & gap_mask) == 64'd0) &&
                       ((addr & high_mask) == 64'd0);
        return dec;
    endfunction

endpackage

// File: rtl/model_config_shadow_mem_if.sv
// Host configuration write port.
//
// Handshake: a write transfers on a rising clock edge where config_valid_i and
// config_ready_o are both high. The host holds address and data stable while
// valid is high and not yet accepted. config_err_o pulses for one cycle after an
// accepted write whose address was illegal; such a write is otherwise dropped.
interface model_config_shadow_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              config_valid_i;
    logic              config_ready_o;
    logic [ADDR_W-1:0] config_addr_i;
    logic [DATA_W-1:0] config_data_i;
    logic              config_err_o;

    modport master (
        output config_valid_i,
        output config_addr_i,
        output config_data_i,
        input  config_ready_o,
        input  config_err_o
    );

    modport slave (
        input  config_valid_i,
        input  config_addr_i,
        input  config_data_i,
        output config_ready_o,
        output config_err_o
    );
endinterface

// File: rtl/model_config_shadow_mem_bank.sv
// One configuration bank: a single write port, a registered consumer read
// port, and a combinational tap used to copy the bank into its twin.
module config_bank #(
    parameter int DATA_W = 32,
    parameter int AW     = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [AW-1:0]     cp_addr_i,
    output logic [DATA_W-1:0] cp_data_o
);
    localparam int DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage update and registered read; reset clears every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem[raddr_i];
            end
        end
    end

    assign rdata_o   = rdata_q;
    assign cp_data_o = mem[cp_addr_i];
endmodule

// File: rtl/model_config_shadow_mem.sv
// Double-buffered model configuration memory. The host edits the shadow bank;
// the accelerator reads the active bank. A commit swaps the banks once the
// accelerator is idle and then copies the new active bank back into the shadow.
module model_config_shadow_mem
    import model_config_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_TABLES  = 4,
    parameter int TABLE_DEPTH = 32,
    parameter int TSEL_LSB    = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    model_config_shadow_mem_if.slave       cfg,
    input  logic                           commit_i,
    input  logic                           busy_i,
    output logic                           pending_o,
    output logic                           commit_done_o,
    input  logic                           rd_en_i,
    input  logic [$clog2(NUM_TABLES)-1:0]  rd_table_i,
    input  logic [$clog2(TABLE_DEPTH)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic                           rd_valid_o,
    output state_t                         dbg_state_o,
    output logic                           dbg_active_sel_o
);
    localparam int TBL_W   = $clog2(NUM_TABLES);
    localparam int IDX_W   = $clog2(TABLE_DEPTH);
    localparam int BANK_AW = TBL_W + IDX_W;
    localparam int D       = NUM_TABLES * TABLE_DEPTH;

    state_t              state;
    logic                active_sel;
    logic [BANK_AW-1:0]  cnt;
    logic                ready_q;
    logic                pend_q;
    logic                done_q;
    logic                err_q;
    logic                rd_valid_q;
    logic                rd_src_q;

    addr_dec_t           dec;
    logic                dec_unused;
    logic                wr_acc;
    logic                copy_last;
    logic                sh_we;
    logic [BANK_AW-1:0]  sh_waddr;
    logic [DATA_W-1:0]   sh_wdata;
    logic [BANK_AW-1:0]  rd_addr;

    logic                we0, we1;
    logic                re0, re1;
    logic [DATA_W-1:0]   rdata0, rdata1;
    logic [DATA_W-1:0]   cp_data0, cp_data1;
    logic [DATA_W-1:0]   cp_active;

    assign dec        = decode_addr(64'(cfg.config_addr_i), ADDR_W, TSEL_LSB,
                                    TBL_W, IDX_W, NUM_TABLES);
    assign dec_unused = ^{dec.table_id[31:TBL_W], dec.idx[31:IDX_W]};
    assign wr_acc     = cfg.config_valid_i && ready_q;
    assign copy_last  = (cnt == BANK_AW'(D - 1));
    assign cp_active  = active_sel ? cp_data1 : cp_data0;
    assign rd_addr    = {rd_table_i, rd_idx_i};

    // Shadow write port: host writes while idle, copy-back traffic while syncing.
    always_comb begin
        sh_we    = 1'b0;
        sh_waddr = '0;
        sh_wdata = '0;
        if (state == ST_SYNC) begin
            sh_we    = 1'b1;
            sh_waddr = cnt;
            sh_wdata = cp_active;
        end else if (wr_acc && dec.legal) begin
            sh_we    = 1'b1;
            sh_waddr = {dec.table_id[TBL_W-1:0], dec.idx[IDX_W-1:0]};
            sh_wdata = cfg.config_data_i;
        end
    end

    // Only the shadow bank is ever written; only the active bank serves reads.
    assign we0 = sh_we && active_sel;
    assign we1 = sh_we && !active_sel;
    assign re0 = rd_en_i && !active_sel;
    assign re1 = rd_en_i && active_sel;

    config_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank0 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (we0),
        .waddr_i   (sh_waddr),
        .wdata_i   (sh_wdata),
        .re_i      (re0),
        .raddr_i   (rd_addr),
        .rdata_o   (rdata0),
        .cp_addr_i (cnt),
        .cp_data_o (cp_data0)
    );

    config_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank1 (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (we1),
        .waddr_i   (sh_waddr),
        .wdata_i   (sh_wdata),
        .re_i      (re1),
        .raddr_i   (rd_addr),
        .rdata_o   (rdata1),
        .cp_addr_i (cnt),
        .cp_data_o (cp_data1)
    );

    // Commit controller: bank flip, copy-back walk and registered status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            active_sel <= 1'b0;
            cnt        <= '0;
            ready_q    <= 1'b0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= wr_acc && !dec.legal;
            case (state)
                ST_IDLE: begin
                    if (commit_i) begin
                        ready_q <= 1'b0;
                        cnt     <= '0;
                        if (busy_i) begin
                            state  <= ST_PEND;
                            pend_q <= 1'b1;
                        end else begin
                            state      <= ST_SYNC;
                            active_sel <= ~active_sel;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!busy_i) begin
                        state      <= ST_SYNC;
                        pend_q     <= 1'b0;
                        active_sel <= ~active_sel;
                        cnt        <= '0;
                    end
                end
                ST_SYNC: begin
                    if (copy_last) begin
                        state   <= ST_IDLE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + BANK_AW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    // Consumer read tracking: remember which bank was active when the read was issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_src_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_src_q <= active_sel;
            end
        end
    end

    assign cfg.config_ready_o = ready_q;
    assign cfg.config_err_o   = err_q;
    assign pending_o          = pend_q;
    assign commit_done_o      = done_q;
    assign rd_data_o          = rd_src_q ? rdata1 : rdata0;
    assign rd_valid_o         = rd_valid_q;
    assign dbg_state_o        = state;
    assign dbg_active_sel_o   = active_sel;
endmodule

// File: tb/tb_model_config_shadow_mem.sv
// Directed bench for the double-buffered model configuration memory.
module tb_model_config_shadow_mem;
    import model_config_pkg::*;

    localparam int D = 128;

    logic        clk;
    logic        rst;
    logic        commit;
    logic        busy;
    logic        pending;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_table;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    state_t      dbg_state;
    logic        dbg_sel;

    int          n_checks;
    int          n_fail;
    logic        exp_sel;

    model_config_shadow_mem_if #(.ADDR_W(32), .DATA_W(32)) cfg ();

    model_config_shadow_mem dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg              (cfg),
        .commit_i         (commit),
        .busy_i           (busy),
        .pending_o        (pending),
        .commit_done_o    (done),
        .rd_en_i          (rd_en),
        .rd_table_i       (rd_table),
        .rd_idx_i         (rd_idx),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .dbg_state_o      (dbg_state),
        .dbg_active_sel_o (dbg_sel)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        cfg.config_valid_i = 1'b1;
        cfg.config_addr_i  = a;
        cfg.config_data_i  = d;
        tick();
        cfg.config_valid_i = 1'b0;
    endtask

    task automatic rd(input int t, input int i, output logic [31:0] d, output logic v);
        rd_en    = 1'b1;
        rd_table = 2'(t);
        rd_idx   = 5'(i);
        tick();
        rd_en = 1'b0;
        d     = rd_data;
        v     = rd_valid;
    endtask

    task automatic pulse_commit;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        exp_sel = ~exp_sel;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 1000);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (cfg.config_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", cfg.config_ready_o); end
        n_checks++; if ({cfg.config_err_o, pending, done, rd_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {cfg.config_err_o, pending, done, rd_valid}); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
        rst = 1'b0;
        tick();
        n_checks++; if (cfg.config_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %0b want 1", cfg.config_ready_o); end
        n_checks++; if (dbg_state !== ST_IDLE || dbg_sel !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0d/%0b want 0/0", dbg_state, dbg_sel); end
    endtask

    task automatic test_basic_commit;
        logic [31:0] d;
        logic v;
        int n;
        for (int i = 0; i < 10; i++) host_write(32'(i), 32'(i));
        pulse_commit();
        n_checks++; if (dbg_sel !== exp_sel || dbg_state !== ST_SYNC) begin n_fail++; $display("FAIL basic_flip: got sel %0b state %0d want sel %0b state 2", dbg_sel, dbg_state, exp_sel); end
        wait_done(n);
        n_checks++; if (n != D) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", n, D); end
        n_checks++; if (cfg.config_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0b want 1", cfg.config_ready_o); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %0b want 0", done); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'd5 || v !== 1'b1) begin n_fail++; $display("FAIL basic_read5: got %0h/%0b want 5/1", d, v); end
        // back-to-back reads
        rd_en = 1'b1; rd_table = 2'd0; rd_idx = 5'd3;
        tick();
        rd_idx = 5'd9;
        n_checks++; if (rd_data !== 32'd3 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_read3: got %0h/%0b want 3/1", rd_data, rd_valid); end
        tick();
        rd_en = 1'b0;
        n_checks++; if (rd_data !== 32'd9) begin n_fail++; $display("FAIL b2b_read9: got %0h want 9", rd_data); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %0b want 0", rd_valid); end
    endtask

    task automatic test_table1;
        logic [31:0] d;
        logic v;
        int n;
        for (int i = 0; i < 32; i++) host_write(32'h100 + 32'(i), 32'(70 + i));
        rd(1, 31, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL t1_precommit31: got %0h want 0", d); end
        rd(1, 0, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL t1_precommit0: got %0h want 0", d); end
        pulse_commit();
        wait_done(n);
        n_checks++; if (n != D) begin n_fail++; $display("FAIL t1_latency: got %0d want %0d", n, D); end
        rd(1, 31, d, v);
        n_checks++; if (d !== 32'd101) begin n_fail++; $display("FAIL t1_read31: got %0d want 101", d); end
        rd(1, 0, d, v);
        n_checks++; if (d !== 32'd70) begin n_fail++; $display("FAIL t1_read0: got %0d want 70", d); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL t1_keep_t0: got %0h want 5", d); end
    endtask

    task automatic test_pending;
        logic [31:0] d;
        logic v;
        int n;
        host_write(32'd5, 32'h55);
        busy = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_checks++; if (pending !== 1'b1 || cfg.config_ready_o !== 1'b0 || dbg_state !== ST_PEND) begin n_fail++; $display("FAIL pend_enter: got pend %0b ready %0b state %0d want 1/0/1", pending, cfg.config_ready_o, dbg_state); end
        n_checks++; if (dbg_sel !== exp_sel) begin n_fail++; $display("FAIL pend_no_flip: got %0b want %0b", dbg_sel, exp_sel); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL pend_old_data: got %0h want 5", d); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        n_checks++; if (pending !== 1'b1 || dbg_sel !== exp_sel) begin n_fail++; $display("FAIL pend_hold: got pend %0b sel %0b want 1/%0b", pending, dbg_sel, exp_sel); end
        busy = 1'b0;
        tick();
        exp_sel = ~exp_sel;
        n_checks++; if (dbg_sel !== exp_sel || pending !== 1'b0 || dbg_state !== ST_SYNC) begin n_fail++; $display("FAIL pend_release: got sel %0b pend %0b state %0d want %0b/0/2", dbg_sel, pending, dbg_state, exp_sel); end
        wait_done(n);
        n_checks++; if (n != D) begin n_fail++; $display("FAIL pend_latency: got %0d want %0d", n, D); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL pend_new_data: got %0h want 55", d); end
    endtask

    task automatic test_sync_boundaries;
        int n;
        pulse_commit();
        repeat (3) tick();
        busy = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_done(n);
        n_checks++; if (n != D - 4) begin n_fail++; $display("FAIL sync_busy_latency: got %0d want %0d", n, D - 4); end
        n_checks++; if (dbg_sel !== exp_sel || pending !== 1'b0) begin n_fail++; $display("FAIL sync_no_requeue: got sel %0b pend %0b want %0b/0", dbg_sel, pending, exp_sel); end
        tick();
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL sync_commit_ignored: got state %0d want 0", dbg_state); end
        busy = 1'b0;
    endtask

    task automatic test_illegal;
        logic [31:0] d;
        logic v;
        int n;
        host_write(32'h400, 32'hDEAD);
        n_checks++; if (cfg.config_err_o !== 1'b1) begin n_fail++; $display("FAIL ill_err_tbl: got %0b want 1", cfg.config_err_o); end
        tick();
        n_checks++; if (cfg.config_err_o !== 1'b0) begin n_fail++; $display("FAIL ill_err_pulse: got %0b want 0", cfg.config_err_o); end
        host_write(32'h20, 32'hBEEF);
        n_checks++; if (cfg.config_err_o !== 1'b1) begin n_fail++; $display("FAIL ill_err_gap: got %0b want 1", cfg.config_err_o); end
        host_write(32'h207, 32'h207);
        n_checks++; if (cfg.config_err_o !== 1'b0) begin n_fail++; $display("FAIL ill_legal_noerr: got %0b want 0", cfg.config_err_o); end
        pulse_commit();
        wait_done(n);
        rd(0, 0, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL ill_dropped: got %0h want 0", d); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'h55) begin n_fail++; $display("FAIL ill_keep: got %0h want 55", d); end
        rd(2, 7, d, v);
        n_checks++; if (d !== 32'h207) begin n_fail++; $display("FAIL ill_legal_write: got %0h want 207", d); end
    endtask

    task automatic test_same_cycle;
        logic [31:0] d;
        logic v;
        int n;
        cfg.config_valid_i = 1'b1;
        cfg.config_addr_i  = 32'd7;
        cfg.config_data_i  = 32'h77;
        commit = 1'b1;
        tick();
        cfg.config_valid_i = 1'b0;
        commit = 1'b0;
        exp_sel = ~exp_sel;
        wait_done(n);
        n_checks++; if (n != D) begin n_fail++; $display("FAIL same_latency: got %0d want %0d", n, D); end
        rd(0, 7, d, v);
        n_checks++; if (d !== 32'h77) begin n_fail++; $display("FAIL same_included: got %0h want 77", d); end
    endtask

    task automatic test_resync;
        logic [31:0] d;
        logic v;
        int n;
        host_write(32'h103, 32'h333);
        pulse_commit();
        wait_done(n);
        rd(1, 3, d, v);
        n_checks++; if (d !== 32'h333) begin n_fail++; $display("FAIL resync_new: got %0h want 333", d); end
        rd(1, 4, d, v);
        n_checks++; if (d !== 32'd74) begin n_fail++; $display("FAIL resync_t1_4: got %0d want 74", d); end
        rd(0, 9, d, v);
        n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL resync_t0_9: got %0h want 9", d); end
        rd(1, 31, d, v);
        n_checks++; if (d !== 32'd101) begin n_fail++; $display("FAIL resync_t1_31: got %0d want 101", d); end
    endtask

    task automatic test_reset_mid_sync;
        logic [31:0] d;
        logic v;
        pulse_commit();
        repeat (10) tick();
        n_checks++; if (dbg_state !== ST_SYNC) begin n_fail++; $display("FAIL rstsync_in_sync: got state %0d want 2", dbg_state); end
        rst = 1'b1;
        tick();
        exp_sel = 1'b0;
        n_checks++; if (dbg_state !== ST_IDLE || dbg_sel !== 1'b0 || cfg.config_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstsync_state: got state %0d sel %0b ready %0b want 0/0/0", dbg_state, dbg_sel, cfg.config_ready_o); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (cfg.config_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstsync_ready: got %0b want 1", cfg.config_ready_o); end
        rd(0, 5, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstsync_t0_5: got %0h want 0", d); end
        rd(1, 31, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstsync_t1_31: got %0h want 0", d); end
        rd(0, 7, d, v);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstsync_t0_7: got %0h want 0", d); end
    endtask

    // Test sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_sel  = 1'b0;
        rst      = 1'b1;
        commit   = 1'b0;
        busy     = 1'b0;
        rd_en    = 1'b0;
        rd_table = '0;
        rd_idx   = '0;
        cfg.config_valid_i = 1'b0;
        cfg.config_addr_i  = '0;
        cfg.config_data_i  = '0;

        test_reset();
        test_basic_commit();
        test_table1();
        test_pending();
        test_sync_boundaries();
        test_illegal();
        test_same_cycle();
        test_resync();
        test_reset_mid_sync();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
